// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and constants for the serial transmit scheduler
package serial_tx_pkg;

    localparam int FRAME_BITS_DEF = 12;
    localparam int SPEED_W_DEF    = 4;

    function automatic int bit_cnt_w(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

    localparam int BIT_CNT_W = bit_cnt_w(FRAME_BITS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DELAY = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/serial_tx_scheduler_arbiter.sv
// rtl/serial_tx_scheduler_arbiter.sv - tx_arbiter winner select; round-robin pointer under SERIAL_TX_RR_EN
module tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic [NREQ-1:0] win,
    output logic            any
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [PTR_W:0] NREQ_V = (PTR_W+1)'(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   idx;

    // Scan starts at ptr and wraps; with fixed priority ptr is tied to zero.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= NREQ_V) begin
                idx = idx - NREQ_V;
            end
            if (!any && req[idx[PTR_W-1:0]]) begin
                any               = 1'b1;
                win_idx           = idx[PTR_W-1:0];
                win[win_idx]      = 1'b1;
            end
        end
    end

`ifdef SERIAL_TX_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (take && any) begin
            ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    logic unused_ok;
    assign unused_ok = ^{clk, reset, take, win_idx};
    assign ptr       = '0;
`endif

endmodule

// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - shared 12-bit serial transmitter scheduler (SERIAL_TX_RR_EN selects round-robin)
module serial_tx_scheduler
    import serial_tx_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int SPEED_W    = SPEED_W_DEF
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NREQ-1:0]            Req,
    input  logic [NREQ*FRAME_BITS-1:0] Data,
    input  logic [NREQ*SPEED_W-1:0]    Speed,
    output logic [NREQ-1:0]            Grant,
    output logic                       Load,
    output logic [FRAME_BITS-1:0]      LoadData,
    output logic                       ShiftOut,
    output logic                       Done,
    output logic                       Busy
);

    localparam int CNT_W = bit_cnt_w(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    tx_state_e               state_q, state_d;
    logic [NREQ-1:0]         grant_q, grant_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [SPEED_W-1:0]      speed_q, speed_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SPEED_W-1:0]      dly_q, dly_d;

    logic [NREQ-1:0]         win;
    logic                    any;
    logic                    take;
    logic [FRAME_BITS-1:0]   sel_frame;
    logic [SPEED_W-1:0]      sel_speed;
    logic [SPEED_W-1:0]      eff_speed;

    assign take = (state_q == ST_IDLE);

    tx_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (Clock),
        .reset (Reset),
        .req   (Req),
        .take  (take),
        .win   (win),
        .any   (any)
    );

    always_comb begin
        sel_frame = '0;
        sel_speed = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                sel_frame = Data[i*FRAME_BITS +: FRAME_BITS];
                sel_speed = Speed[i*SPEED_W +: SPEED_W];
            end
        end
    end

    // A zero speed field paces like one clock per bit.
    assign eff_speed = (sel_speed == '0) ? SPEED_W'(1) : sel_speed;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        frame_d   = frame_q;
        speed_d   = speed_q;
        bit_cnt_d = bit_cnt_q;
        dly_d     = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_LOAD;
                    grant_d = win;
                    frame_d = sel_frame;
                    speed_d = eff_speed;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else if (speed_q == SPEED_W'(1)) begin
                    state_d = ST_SHIFT;
                end else begin
                    // speed_q >= 2 here, so the subtraction cannot wrap.
                    dly_d   = speed_q - SPEED_W'(2);
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    dly_d = dly_q - SPEED_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            frame_q   <= '0;
            speed_q   <= '0;
            bit_cnt_q <= '0;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            frame_q   <= frame_d;
            speed_q   <= speed_d;
            bit_cnt_q <= bit_cnt_d;
            dly_q     <= dly_d;
        end
    end

    assign Grant    = grant_q;
    assign Load     = (state_q == ST_LOAD);
    assign LoadData = Load ? frame_q : '0;
    assign ShiftOut = (state_q == ST_SHIFT);
    assign Done     = (state_q == ST_DONE);
    assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb/tb_serial_tx_scheduler.sv - directed table-driven bench for serial_tx_scheduler
module tb_serial_tx_scheduler;

    localparam int FB = 12;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] frame;
        logic [3:0]  spd;
        logic [3:0]  exp_grant;
        int          exp_s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] data;
    logic [15:0] speed;
    logic [3:0]  grant;
    logic        load;
    logic [11:0] load_data;
    logic        shift_out;
    logic        done;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int last_load_cyc = 0;
    int last_done_cyc = 0;

    vec_t vecs[7];

    always #5 clk = ~clk;

    serial_tx_scheduler #(.NREQ(4), .FRAME_BITS(12), .SPEED_W(4)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Req      (req),
        .Data     (data),
        .Speed    (speed),
        .Grant    (grant),
        .Load     (load),
        .LoadData (load_data),
        .ShiftOut (shift_out),
        .Done     (done),
        .Busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input string name, input logic [3:0] exp_grant,
                             input logic [11:0] exp_frame, input int s, input bit drop);
        bit seen;
        bit excl_bad;
        int c;
        int shifts;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            tick();
            if (load) seen = 1'b1;
        end
        if (!seen) begin
            check($sformatf("%s_load_timeout", name), 0, 1);
            return;
        end
        last_load_cyc = cyc;
        check($sformatf("%s_grant_at_load", name), 32'(grant), 32'(exp_grant));
        check($sformatf("%s_load_data", name), 32'(load_data), 32'(exp_frame));
        check($sformatf("%s_busy_at_load", name), 32'(busy), 1);
        if (drop) begin
            req   = '0;
            data  = ~data;
            speed = '1;
        end
        c = 0;
        shifts = 0;
        excl_bad = 1'b0;
        seen = 1'b0;
        while (!seen && c < 300) begin
            tick();
            c++;
            if (int'(load) + int'(shift_out) + int'(done) > 1) excl_bad = 1'b1;
            if (load) excl_bad = 1'b1;
            if (shift_out) begin
                check($sformatf("%s_shift%0d_at", name, shifts), c, 1 + shifts * s);
                shifts++;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check($sformatf("%s_done_timeout", name), 0, 1);
            return;
        end
        last_done_cyc = cyc;
        check($sformatf("%s_done_at", name), c, 2 + (FB - 1) * s);
        check($sformatf("%s_shift_count", name), shifts, FB);
        check($sformatf("%s_grant_at_done", name), 32'(grant), 32'(exp_grant));
        check($sformatf("%s_strobe_exclusive", name), 32'(excl_bad), 0);
        tick();
        check($sformatf("%s_grant_after", name), 32'(grant), 0);
        check($sformatf("%s_busy_after", name), 32'(busy), 0);
    endtask

    function automatic int onehot_idx(input logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [3:0]  cont_req;
        logic [3:0]  cont_exp[5];
        logic [3:0]  gexp;
        int          nshift;
        bit          seen;
        bit          bad;

        vecs[0] = '{4'b0001, 12'hA5C, 4'd1,  4'b0001, 1};
        vecs[1] = '{4'b0001, 12'h3C5, 4'd3,  4'b0001, 3};
        vecs[2] = '{4'b0001, 12'h0F0, 4'd0,  4'b0001, 1};
        vecs[3] = '{4'b0100, 12'h3C7, 4'd2,  4'b0100, 2};
        vecs[4] = '{4'b1000, 12'hFFF, 4'd15, 4'b1000, 15};
        vecs[5] = '{4'b0110, 12'h5A5, 4'd4,  4'b0010, 4};
        vecs[6] = '{4'b1100, 12'h123, 4'd1,  4'b0100, 1};

`ifdef SERIAL_TX_RR_EN
        cont_req = 4'b1111;
        cont_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        cont_req = 4'b1010;
        cont_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif

        rst   = 1'b1;
        req   = '0;
        data  = '0;
        speed = '0;
        tick();
        tick();
        check("reset_grant", 32'(grant), 0);
        check("reset_strobes", 32'({load, shift_out, done, busy}), 0);
        check("reset_load_data", 32'(load_data), 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].exp_grant[i]) begin
                    data[i*12 +: 12] = vecs[v].frame;
                    speed[i*4 +: 4]  = vecs[v].spd;
                end else begin
                    data[i*12 +: 12] = ~vecs[v].frame ^ 12'(i);
                    speed[i*4 +: 4]  = 4'd7;
                end
            end
            req = vecs[v].req;
            run_frame($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].frame, vecs[v].exp_s, 1'b1);
            tick();
        end

        // Reset on the 5th shift of a frame from requester 2.
        data  = {12'h444, 12'h333, 12'h222, 12'h111};
        speed = 16'h1111;
        req   = 4'b0100;
        seen  = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            tick();
            if (load) seen = 1'b1;
        end
        check("rst_mid_load_seen", 32'(seen), 1);
        req = '0;
        nshift = 0;
        for (int w = 0; w < 40 && nshift < 5; w++) begin
            tick();
            if (shift_out) nshift++;
        end
        check("rst_mid_shift5_seen", nshift, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_grant", 32'(grant), 0);
        check("rst_mid_strobes", 32'({load, shift_out, done, busy}), 0);
        check("rst_mid_load_data", 32'(load_data), 0);
        bad = 1'b0;
        for (int w = 0; w < 20; w++) begin
            tick();
            if (done || busy || shift_out) bad = 1'b1;
        end
        check("rst_mid_no_done", 32'(bad), 0);

        // Held contention: grant order and one IDLE cycle between frames.
        req = cont_req;
        for (int f = 0; f < 5; f++) begin
            gexp = cont_exp[f];
            run_frame($sformatf("cont%0d", f), gexp, 12'h111 * 12'(onehot_idx(gexp) + 1), 1, 1'b0);
            if (f > 0) begin
                check($sformatf("cont%0d_load_gap", f), last_load_cyc - prev_done(), 2);
            end
            save_done();
        end
        req = '0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    int prev_done_cyc = 0;

    function automatic int prev_done();
        return prev_done_cyc;
    endfunction

    task automatic save_done();
        prev_done_cyc = last_done_cyc;
    endtask

endmodule

// File: doc/serial_tx_scheduler.md
# serial_tx_scheduler

Shares one serial shift-out transmitter (12-bit frame, per-bit pacing) among NREQ requesters. Arbitrates between requests, latches the winner's frame and speed, and drives the transmitter's Load/ShiftOut strobes and parallel load data. It sits between the requesting blocks and the shift-register datapath, and replaces per-requester transmit control.

## Interface
- NREQ, 4, number of requesters (2..8)
- FRAME_BITS, 12, bits shifted per frame
- SPEED_W, 4, width of each per-requester speed field
- Clock  in  1  rising-edge system clock
- Reset  in  1  synchronous, active-high; one clock, reset sampled on rising edge of Clock
- Req  in  NREQ  per-requester transmit request, level
- Data  in  NREQ*FRAME_BITS  frames; requester i at [i*FRAME_BITS +: FRAME_BITS]
- Speed  in  NREQ*SPEED_W  clocks per bit; requester i at [i*SPEED_W +: SPEED_W]
- Grant  out  NREQ  one-hot owner of the transmitter, 0 when idle
- Load  out  1  one-cycle parallel-load strobe to shift register
- LoadData  out  FRAME_BITS  frame to load, valid while Load=1
- ShiftOut  out  1  one-cycle shift strobe, one per bit
- Done  out  1  one-cycle frame-complete pulse
- Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, SHIFT, DELAY, DONE; all outputs are registered or decoded from registered state.
- IDLE: if Req!=0, the arbiter picks winner w. Next cycle: LOAD, Grant=onehot(w), frame and speed latched from requester w. Otherwise stay in IDLE.
- LOAD: Load=1, LoadData=latched frame. Bit counter cleared. Go to SHIFT.
- SHIFT: ShiftOut=1, bit counter +1.
  - If this is bit FRAME_BITS, go to DONE.
  - Else if effective speed S'=1, stay in SHIFT.
  - Else load the delay counter with S'-2 and go to DELAY.
- DELAY: all strobes 0. Count down. At 0, go to SHIFT.
- Effective speed S' = Speed, with Speed=0 treated as 1. The delay counter is SPEED_W bits wide and never underflows.
- DONE: Done=1, Grant still held. Next cycle: IDLE, Grant=0.
- Req is sampled only in IDLE.
  - Dropping Req mid-frame does not abort; the frame completes.
  - Req still high in the IDLE cycle after Done rearbitrates normally.
  - Data and Speed changes after LOAD have no effect.
- Reset at any time:
  - State=IDLE; Grant=0, Load=0, ShiftOut=0, Done=0, Busy=0, LoadData=0.
  - Counters=0 and the round-robin pointer=0.
  - The in-flight frame is discarded with no Done.

## Timing
- Load in cycle t0, which is the cycle after the IDLE cycle that sampled Req. Grant and Busy rise in t0.
- Shift k (k=0..FRAME_BITS-1) asserts in t0+1+k*S'.
- Done asserts in t0+2+(FRAME_BITS-1)*S'. With S'=1, FRAME_BITS=12, Done is at t0+13.
- Grant falls, Busy falls and state is IDLE in the cycle after Done.
- The next Load is no earlier than Done+2 (one IDLE cycle between frames, always).
- Load, ShiftOut and Done are mutually exclusive in every cycle.

## Configuration
- SERIAL_TX_RR_EN defined:
  - Round-robin arbitration. The search starts at the pointer and wraps modulo NREQ.
  - The pointer becomes w+1 (mod NREQ) on grant.
- Not defined:
  - Fixed priority, lowest index wins.
  - No pointer register exists.

## Structure
- Shared package serial_tx_pkg holds:
  - the state enum type and its encoding;
  - default constants FRAME_BITS=12 and SPEED_W=4;
  - the bit counter width $clog2(FRAME_BITS+1).
- Sub-module tx_arbiter: combinational winner selection from Req and the pointer, plus the pointer register when SERIAL_TX_RR_EN is defined.
- The FSM, counters, latches and output registers stay in serial_tx_scheduler.

## Test plan
- Single frame: Req=0001, Data0=12'hA5C, Speed0=1 -> Load with LoadData=A5C one cycle after the sample cycle; 12 consecutive ShiftOut; Done at Load+13; Grant=0001 throughout, then 0.
- Pacing: Speed0=3 -> ShiftOut every 3rd cycle, 12 pulses, Done at Load+35. Speed0=0 behaves exactly as Speed0=1.
- Contention with SERIAL_TX_RR_EN: Req=1111 held -> grants 0001, 0010, 0100, 1000, 0001. Each Load is exactly Done+2 after the prior frame's Done.
- Contention without the macro: Req=1010 held -> Grant=0010 on every frame; requester 3 is never served.
- Mid-frame Req drop and Data change after Load -> frame completes unchanged; Done still pulses; then IDLE.
- Reset asserted at the 5th ShiftOut -> next cycle all outputs 0 and state IDLE with no Done. With SERIAL_TX_RR_EN, the next grant under Req=1111 is 0001.
